// File: rtl/packet_buffer.sv
// -----------------------------------------------------------------------------
// packet_buffer
//   Packet-granular store-and-forward buffer for an AXI-Stream switch port.
//   Beats are written into a circular memory; a packet only becomes visible on
//   the release stream once its tlast beat has been stored (committed). A
//   packet that cannot fit is rolled back and the rest of it is discarded.
//
// Handshake: on both streams a beat transfers on a rising edge where tvalid
//   and tready are both high. The source holds tdata/tkeep/tuser/tlast stable
//   while tvalid is high and tready is low. tvalid never waits for tready.
//
// Ports
//   axis_aclk, axis_reset      clock, asynchronous active-high reset
//   s_axis_*                   write stream from the switch buffer port
//   m_axis_*                   release stream back to the switch
//   pkt_count                  complete packets stored, not yet fully read
//   beat_count                 beats in memory (wr_ptr - rd_ptr)
//   drop_count                 packets dropped since reset (saturating)
//   full                       beat_count == DEPTH
//   dbg_wr_state               write FSM state (0 IDLE, 1 WRITE, 2 DROP)
// -----------------------------------------------------------------------------
module packet_buffer #(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_TUSER_WIDTH = 256,
  parameter int DEPTH_LOG2       = 6
) (
  input  logic                          axis_aclk,
  input  logic                          axis_reset,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [DEPTH_LOG2:0]           pkt_count,
  output logic [DEPTH_LOG2:0]           beat_count,
  output logic [15:0]                   drop_count,
  output logic                          full,
  output logic [1:0]                    dbg_wr_state
);

  localparam int DW    = AXIS_DATA_WIDTH;
  localparam int KW    = AXIS_DATA_WIDTH / 8;
  localparam int UW    = AXIS_TUSER_WIDTH;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int EW    = DW + KW + UW + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [PW-1:0] DEPTH_V = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } wr_state_t;

  // Memory entry layout: {tdata, tkeep, tuser, tlast}, tlast in bit 0.
  logic [EW-1:0] r_mem [DEPTH];

  wr_state_t     r_state;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_pkt_start;
  logic [PW-1:0] r_commit_ptr;
  logic [PW-1:0] r_fetch_ptr;   // next address to read from memory
  logic [PW-1:0] r_rd_ptr;      // beats handed to the output register
  logic [PW-1:0] r_pkt_count;
  logic [15:0]   r_drop_count;
  logic          r_ready_en;    // low in reset, high from the first edge after
  logic          r_q_valid;     // memory read register holds a beat
  logic [EW-1:0] r_q_data;
  logic          r_out_valid;
  logic [EW-1:0] r_out_data;

  logic [PW-1:0] w_beat_count;
  logic          w_full;
  logic          w_wr_fire;
  logic          w_rollback;
  logic          w_commit;
  logic          w_out_ready;
  logic          w_fetch;
  logic          w_load;
  logic          w_rd_last;
  logic [EW-1:0] w_wr_entry;

  // Occupancy is computed from registered pointers only, so a read in the
  // same cycle never frees space for a write.
  assign w_beat_count = r_wr_ptr - r_rd_ptr;
  assign w_full       = (w_beat_count == DEPTH_V);

  assign s_axis_tready = r_ready_en & ((r_state == ST_DROP) | ~w_full);
  assign w_wr_fire     = s_axis_tvalid & s_axis_tready & (r_state != ST_DROP);
  assign w_commit      = w_wr_fire & s_axis_tlast;
  // A beat arriving mid-packet with no room means the packet cannot fit.
  assign w_rollback    = (r_state == ST_WRITE) & s_axis_tvalid & w_full;
  assign w_wr_entry    = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};

  // Two-stage read path: memory read register, then output register. The
  // memory read register refills whenever its beat moves on, giving full rate.
  assign w_out_ready = ~r_out_valid | m_axis_tready;
  assign w_fetch     = (r_fetch_ptr != r_commit_ptr) & (~r_q_valid | w_out_ready);
  assign w_load      = r_q_valid & w_out_ready;
  assign w_rd_last   = r_out_valid & m_axis_tready & r_out_data[0];

  always_ff @(posedge axis_aclk) begin
    if (w_wr_fire) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= w_wr_entry;
  end

  // Write FSM plus the packet/drop counters.
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_pkt_start  <= '0;
      r_commit_ptr <= '0;
      r_pkt_count  <= '0;
      r_drop_count <= '0;
      r_ready_en   <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      case (r_state)
        ST_IDLE, ST_WRITE: begin
          if (w_rollback) begin
            r_wr_ptr <= r_pkt_start;
            r_state  <= ST_DROP;
            if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
          end else if (w_wr_fire) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
            if (r_state == ST_IDLE) r_pkt_start <= r_wr_ptr;
            if (s_axis_tlast) begin
              r_commit_ptr <= r_wr_ptr + PW'(1);
              r_state      <= ST_IDLE;
            end else begin
              r_state <= ST_WRITE;
            end
          end
        end
        ST_DROP: begin
          if (s_axis_tvalid & s_axis_tready & s_axis_tlast) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      case ({w_commit, w_rd_last})
        2'b10:   r_pkt_count <= r_pkt_count + PW'(1);
        2'b01:   r_pkt_count <= r_pkt_count - PW'(1);
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

  // Read side. Only committed addresses are fetched, so a rollback never
  // touches anything already in the read path.
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      r_fetch_ptr <= '0;
      r_rd_ptr    <= '0;
      r_q_valid   <= 1'b0;
      r_q_data    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_fetch) begin
        r_q_data    <= r_mem[r_fetch_ptr[DEPTH_LOG2-1:0]];
        r_fetch_ptr <= r_fetch_ptr + PW'(1);
        r_q_valid   <= 1'b1;
      end else if (w_load) begin
        r_q_valid <= 1'b0;
      end

      if (w_load) begin
        r_out_data  <= r_q_data;
        r_out_valid <= 1'b1;
        r_rd_ptr    <= r_rd_ptr + PW'(1);
      end else if (r_out_valid & m_axis_tready) begin
        // Emptied output register reads as all zeros.
        r_out_data  <= '0;
        r_out_valid <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tdata  = r_out_data[EW-1 -: DW];
  assign m_axis_tkeep  = r_out_data[UW+KW -: KW];
  assign m_axis_tuser  = r_out_data[UW -: UW];
  assign m_axis_tlast  = r_out_data[0];

  assign pkt_count    = r_pkt_count;
  assign beat_count   = w_beat_count;
  assign drop_count   = r_drop_count;
  assign full         = w_full;
  assign dbg_wr_state = r_state;

endmodule

// File: tb/tb_packet_buffer.sv
// -----------------------------------------------------------------------------
// tb_packet_buffer
//   Self-checking bench for packet_buffer with narrow data paths and a
//   64-beat memory. Surviving beats are pushed to exp_q when accepted on the
//   write side; a negedge monitor pops and compares on every release handshake
//   and checks that stalled outputs hold and idle outputs read zero.
// -----------------------------------------------------------------------------
module tb_packet_buffer;

  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int UW = 8;
  localparam int DL = 6;
  localparam int BW = DW + KW + UW + 1;

  logic          axis_aclk = 1'b0;
  logic          axis_reset;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [DL:0]   pkt_count;
  logic [DL:0]   beat_count;
  logic [15:0]   drop_count;
  logic          full;
  logic [1:0]    dbg_wr_state;

  packet_buffer #(
    .AXIS_DATA_WIDTH  (DW),
    .AXIS_TUSER_WIDTH (UW),
    .DEPTH_LOG2       (DL)
  ) dut (
    .axis_aclk     (axis_aclk),
    .axis_reset    (axis_reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .pkt_count     (pkt_count),
    .beat_count    (beat_count),
    .drop_count    (drop_count),
    .full          (full),
    .dbg_wr_state  (dbg_wr_state)
  );

  // ---------------- clock ----------------
  always #5 axis_aclk = ~axis_aclk;

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            exp_drop = 0;
  bit            rand_rdy = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] mk_beat(input bit last);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    d = DW'($urandom);
    k = KW'($urandom_range(1, (1 << KW) - 1));
    u = UW'($urandom_range(0, (1 << UW) - 1));
    return {d, k, u, last};
  endfunction

  // ---------------- monitor ----------------
  logic [BW-1:0] held;
  bit            hold = 0;

  always @(negedge axis_aclk) begin
    logic [BW-1:0] cur;
    logic [BW-1:0] e;
    cur = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
    if (axis_reset) begin
      hold = 0;
    end else begin
      if (hold) begin
        check("stall_valid", 64'(m_axis_tvalid), 64'd1);
        check("stall_data", 64'(cur), 64'(held));
      end
      if (!m_axis_tvalid) check("idle_zero", 64'(cur), 64'd0);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got %0h expected none at %0t", cur, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_beat", 64'(cur), 64'(e));
        end
      end
      hold = m_axis_tvalid && !m_axis_tready;
      held = cur;
    end
  end

  // Random release backpressure, enabled only by the mixed-length test.
  initial begin
    forever begin
      @(posedge axis_aclk);
      #1;
      if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [BW-1:0] b, output int stalls);
    bit ok;
    stalls = 0;
    ok = 0;
    {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast} = b;
    s_axis_tvalid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge axis_aclk);
      if (s_axis_tready) begin
        ok = 1;
        break;
      end
      stalls++;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL write_timeout: got tready 0 expected 1 at %0t", $time);
    end
    @(posedge axis_aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit keep_it);
    logic [BW-1:0] b;
    int st;
    for (int i = 0; i < len; i++) begin
      b = mk_beat(i == len - 1);
      drive_beat(b, st);
      if (keep_it) exp_q.push_back(b);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    m_axis_tready = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      @(negedge axis_aclk);
      if (exp_q.size() == 0 && !m_axis_tvalid) begin
        ok = 1;
        break;
      end
    end
    check("drain_done", 64'(ok), 64'd1);
    check("drain_pkt_count", 64'(pkt_count), 64'd0);
    check("drain_beat_count", 64'(beat_count), 64'd0);
    @(posedge axis_aclk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int len;
    int exp_beats;
    int exp_pkts;
    bit exp_full;
    bit drops;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [BW-1:0] b;
    int st;
    int waited;

    tbl[0] = '{len: 1,  exp_beats: 1,  exp_pkts: 1, exp_full: 1'b0, drops: 1'b0};
    tbl[1] = '{len: 5,  exp_beats: 5,  exp_pkts: 1, exp_full: 1'b0, drops: 1'b0};
    tbl[2] = '{len: 64, exp_beats: 64, exp_pkts: 1, exp_full: 1'b1, drops: 1'b0};
    tbl[3] = '{len: 65, exp_beats: 0,  exp_pkts: 0, exp_full: 1'b0, drops: 1'b1};
    tbl[4] = '{len: 70, exp_beats: 0,  exp_pkts: 0, exp_full: 1'b0, drops: 1'b1};

    // ---- reset state ----
    axis_reset    = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    #1;
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_counts", 64'({pkt_count, beat_count, drop_count, full}), 64'd0);
    repeat (3) @(posedge axis_aclk);
    @(negedge axis_aclk);
    axis_reset = 1'b0;
    #1;
    check("rel_tready_pre_edge", 64'(s_axis_tready), 64'd0);
    @(posedge axis_aclk);
    #1;
    check("rel_tready_post_edge", 64'(s_axis_tready), 64'd1);

    // ---- 3-beat packet, release latency ----
    m_axis_tready = 1'b1;
    send_pkt(3, 1);
    check("lat_valid_n0", 64'(m_axis_tvalid), 64'd0);
    @(posedge axis_aclk);
    #1;
    check("lat_valid_n1", 64'(m_axis_tvalid), 64'd0);
    check("lat_pkt_count", 64'(pkt_count), 64'd1);
    @(posedge axis_aclk);
    #1;
    check("lat_valid_n2", 64'(m_axis_tvalid), 64'd1);
    drain();

    // ---- table: single packets into an empty buffer, release stalled ----
    for (int v = 0; v < 5; v++) begin
      m_axis_tready = 1'b0;
      send_pkt(tbl[v].len, !tbl[v].drops);
      if (tbl[v].drops) exp_drop++;
      check("tbl_beat_count", 64'(beat_count), 64'(tbl[v].exp_beats));
      check("tbl_pkt_count", 64'(pkt_count), 64'(tbl[v].exp_pkts));
      check("tbl_full", 64'(full), 64'(tbl[v].exp_full));
      check("tbl_drop_count", 64'(drop_count), 64'(exp_drop));
      repeat (4) @(posedge axis_aclk);
      #1;
      check("tbl_mvalid", 64'(m_axis_tvalid), 64'(tbl[v].exp_pkts != 0));
      drain();
    end

    // ---- full buffer, second packet dropped ----
    m_axis_tready = 1'b0;
    send_pkt(64, 1);
    check("full_after_64", 64'(full), 64'd1);
    check("beats_after_64", 64'(beat_count), 64'd64);
    // First beat waits two cycles for the head beat to move into the output
    // register and free one slot; the second beat finds the buffer full again.
    b = mk_beat(1'b0);
    drive_beat(b, st);
    check("p2_b1_stalls", 64'(st), 64'd2);
    b = mk_beat(1'b0);
    drive_beat(b, st);
    check("p2_b2_stalls", 64'(st), 64'd1);
    b = mk_beat(1'b0);
    drive_beat(b, st);
    check("p2_b3_stalls", 64'(st), 64'd0);
    b = mk_beat(1'b1);
    drive_beat(b, st);
    check("p2_b4_stalls", 64'(st), 64'd0);
    exp_drop++;
    check("p2_drop_count", 64'(drop_count), 64'(exp_drop));
    check("p2_pkt_count", 64'(pkt_count), 64'd1);
    check("p2_beat_count", 64'(beat_count), 64'd63);
    check("p2_state_idle", 64'(dbg_wr_state), 64'd0);
    drain();

    // ---- continuous 1-beat packets across pointer wrap ----
    m_axis_tready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send_pkt(1, 1);
      if (i >= 6) begin
        check("stream_pkt_count", 64'(pkt_count), 64'd3);
        check("stream_beat_count", 64'(beat_count), 64'd2);
      end
    end
    drain();

    // ---- random backpressure, mixed lengths ----
    rand_rdy = 1;
    for (int p = 0; p < 10; p++) begin
      int len;
      len = $urandom_range(1, 20);
      waited = 0;
      while (exp_q.size() + len > 60 && waited < 2000) begin
        @(posedge axis_aclk);
        #1;
        waited++;
      end
      repeat ($urandom_range(0, 3)) @(posedge axis_aclk);
      #1;
      send_pkt(len, 1);
    end
    rand_rdy = 0;
    #2;
    drain();
    check("rand_drop_count", 64'(drop_count), 64'(exp_drop));

    // ---- reset mid-packet on both sides ----
    m_axis_tready = 1'b0;
    send_pkt(5, 1);
    for (int i = 0; i < 3; i++) begin
      b = mk_beat(1'b0);
      drive_beat(b, st);
    end
    m_axis_tready = 1'b1;
    repeat (2) @(posedge axis_aclk);
    #1;
    m_axis_tready = 1'b0;
    #2;
    axis_reset = 1'b1;
    #1;
    exp_q.delete();
    check("arst_pkt_count", 64'(pkt_count), 64'd0);
    check("arst_beat_count", 64'(beat_count), 64'd0);
    check("arst_drop_count", 64'(drop_count), 64'd0);
    check("arst_full", 64'(full), 64'd0);
    check("arst_mvalid", 64'(m_axis_tvalid), 64'd0);
    check("arst_mlast", 64'(m_axis_tlast), 64'd0);
    check("arst_mdata", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tuser}), 64'd0);
    check("arst_tready", 64'(s_axis_tready), 64'd0);
    repeat (2) @(posedge axis_aclk);
    @(negedge axis_aclk);
    axis_reset = 1'b0;
    @(posedge axis_aclk);
    #1;
    check("arst_tready_after", 64'(s_axis_tready), 64'd1);
    send_pkt(4, 1);
    check("arst_new_pkt", 64'(pkt_count), 64'd1);
    drain();
    check("arst_final_drop", 64'(drop_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
